// File: rtl/rx_demux.sv
// ---------------------------------------------------------------------------
// rx_demux
//
// Receive-side block demultiplexer. Each accepted 512-bit block is steered
// by its sync header to either the data path (TLP/DLLP blocks, header 0)
// or the ordered-set path (header 1). The selected output registers update
// one cycle after the block is presented. The path that does not carry a
// block in a given cycle drives en=0 and valid_out=0 and holds its payload
// and K/D registers.
//
// A small mode FSM (IDLE / OS / DATA) follows the stream type. It switches
// only after SWITCH_COUNT consecutive accepted blocks of the other type.
// Idle cycles and ignored blocks neither advance nor clear that run.
// Routing never depends on the mode; the mode is status only.
//
// A block is accepted when rx_block_valid=1 and at least one rx_valid bit
// is set. A block with rx_valid=0 has no effect at all.
//
// Optional feature: define RX_DEMUX_STATS_EN to build saturating per-type
// accepted-block counters. Without the macro the counter outputs are
// tied to 0 and no counter registers exist.
//
// Parameters:
//   SWITCH_COUNT  consecutive opposite-type blocks needed to change mode (1..15)
//   CNT_W         statistics counter width
//
// Ports:
//   clk             clock; all state updates on its rising edge
//   reset           synchronous, active-high reset
//   rx_block_valid  a block is presented this cycle
//   rx_sync_header  1 = ordered-set block, 0 = data block
//   rx_data/rx_valid/rx_datak           block payload, per-byte valid, per-byte K/D
//   data_out/data_valid_out/data_datak_out/data_out_en   data path output
//   os_out/os_valid_out/os_datak_out/os_out_en           ordered-set path output
//   mode            stream mode (00 IDLE, 01 OS, 10 DATA)
//   mode_change     one-cycle pulse in the cycle the mode updates
//   os_blk_cnt/data_blk_cnt  accepted-block counters
// ---------------------------------------------------------------------------
module rx_demux #(
  parameter int SWITCH_COUNT = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_block_valid,
  input  logic             rx_sync_header,
  input  logic [511:0]     rx_data,
  input  logic [63:0]      rx_valid,
  input  logic [63:0]      rx_datak,
  output logic [511:0]     data_out,
  output logic [63:0]      data_valid_out,
  output logic [63:0]      data_datak_out,
  output logic             data_out_en,
  output logic [511:0]     os_out,
  output logic [63:0]      os_valid_out,
  output logic [63:0]      os_datak_out,
  output logic             os_out_en,
  output logic [1:0]       mode,
  output logic             mode_change,
  output logic [CNT_W-1:0] os_blk_cnt,
  output logic [CNT_W-1:0] data_blk_cnt
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_OS   = 2'b01,
    MODE_DATA = 2'b10
  } mode_e;

  // Run counter is sized for the largest legal SWITCH_COUNT (15).
  localparam int RUN_W = 4;
  localparam logic [RUN_W:0] SWITCH_RUN = (RUN_W+1)'(SWITCH_COUNT);

  logic           accept_s;
  mode_e          blk_type_s;
  logic [RUN_W:0] run_inc_s;
  logic [RUN_W:0] run_next_s;
  mode_e          cand_next_s;
  logic           hit_s;
  logic           mode_illegal_s;

  logic [511:0]   data_out_r;
  logic [63:0]    data_valid_r;
  logic [63:0]    data_datak_r;
  logic           data_en_r;
  logic [511:0]   os_out_r;
  logic [63:0]    os_valid_r;
  logic [63:0]    os_datak_r;
  logic           os_en_r;

  mode_e          mode_r;
  mode_e          cand_r;
  logic [RUN_W-1:0] run_r;
  logic           mode_change_r;

  assign accept_s   = rx_block_valid && (rx_valid != 64'd0);
  assign blk_type_s = rx_sync_header ? MODE_OS : MODE_DATA;
  assign run_inc_s  = {1'b0, run_r} + {{RUN_W{1'b0}}, 1'b1};
  assign hit_s      = (run_next_s == SWITCH_RUN);

  // Run/candidate value the current block would produce if it is accepted.
  always_comb begin
    cand_next_s    = cand_r;
    run_next_s     = {1'b0, run_r};
    mode_illegal_s = 1'b0;
    case (mode_r)
      MODE_IDLE: begin
        // A fresh run, or a type different from the candidate, restarts at 1.
        if ((run_r == {RUN_W{1'b0}}) || (cand_r != blk_type_s)) begin
          cand_next_s = blk_type_s;
          run_next_s  = {{RUN_W{1'b0}}, 1'b1};
        end else begin
          run_next_s  = run_inc_s;
        end
      end
      MODE_OS, MODE_DATA: begin
        // A block matching the current mode breaks any pending switch.
        if (blk_type_s == mode_r) begin
          run_next_s  = {(RUN_W+1){1'b0}};
        end else begin
          cand_next_s = blk_type_s;
          run_next_s  = run_inc_s;
        end
      end
      default: begin
        cand_next_s    = MODE_IDLE;
        run_next_s     = {(RUN_W+1){1'b0}};
        mode_illegal_s = 1'b1;
      end
    endcase
  end

  // Output path registers: steer accepted blocks by sync header, hold idle payloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r   <= {512{1'b0}};
      data_valid_r <= 64'd0;
      data_datak_r <= 64'd0;
      data_en_r    <= 1'b0;
      os_out_r     <= {512{1'b0}};
      os_valid_r   <= 64'd0;
      os_datak_r   <= 64'd0;
      os_en_r      <= 1'b0;
    end else if (accept_s && rx_sync_header) begin
      os_out_r     <= rx_data;
      os_valid_r   <= rx_valid;
      os_datak_r   <= rx_datak;
      os_en_r      <= 1'b1;
      data_valid_r <= 64'd0;
      data_en_r    <= 1'b0;
    end else if (accept_s) begin
      data_out_r   <= rx_data;
      data_valid_r <= rx_valid;
      data_datak_r <= rx_datak;
      data_en_r    <= 1'b1;
      os_valid_r   <= 64'd0;
      os_en_r      <= 1'b0;
    end else begin
      data_valid_r <= 64'd0;
      data_en_r    <= 1'b0;
      os_valid_r   <= 64'd0;
      os_en_r      <= 1'b0;
    end
  end

  // Mode FSM: advance the run on accepted blocks, switch when it reaches SWITCH_COUNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r        <= MODE_IDLE;
      cand_r        <= MODE_IDLE;
      run_r         <= {RUN_W{1'b0}};
      mode_change_r <= 1'b0;
    end else if (mode_illegal_s) begin
      // Corrupted state encoding: fall back to IDLE and rebuild the run.
      mode_r        <= MODE_IDLE;
      cand_r        <= MODE_IDLE;
      run_r         <= {RUN_W{1'b0}};
      mode_change_r <= 1'b0;
    end else if (accept_s) begin
      if (hit_s) begin
        mode_r        <= cand_next_s;
        cand_r        <= cand_next_s;
        run_r         <= {RUN_W{1'b0}};
        mode_change_r <= 1'b1;
      end else begin
        cand_r        <= cand_next_s;
        run_r         <= run_next_s[RUN_W-1:0];
        mode_change_r <= 1'b0;
      end
    end else begin
      mode_change_r <= 1'b0;
    end
  end

`ifdef RX_DEMUX_STATS_EN
  logic [CNT_W-1:0] os_cnt_r;
  logic [CNT_W-1:0] data_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Accepted-block statistics, updating on the same edge as the output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      os_cnt_r   <= {CNT_W{1'b0}};
      data_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && rx_sync_header) begin
      os_cnt_r   <= sat_inc(os_cnt_r);
    end else if (accept_s) begin
      data_cnt_r <= sat_inc(data_cnt_r);
    end else begin
      os_cnt_r   <= os_cnt_r;
      data_cnt_r <= data_cnt_r;
    end
  end

  assign os_blk_cnt   = os_cnt_r;
  assign data_blk_cnt = data_cnt_r;
`else
  assign os_blk_cnt   = {CNT_W{1'b0}};
  assign data_blk_cnt = {CNT_W{1'b0}};
`endif

  assign data_out       = data_out_r;
  assign data_valid_out = data_valid_r;
  assign data_datak_out = data_datak_r;
  assign data_out_en    = data_en_r;
  assign os_out         = os_out_r;
  assign os_valid_out   = os_valid_r;
  assign os_datak_out   = os_datak_r;
  assign os_out_en      = os_en_r;
  assign mode           = mode_r;
  assign mode_change    = mode_change_r;

endmodule

// File: tb/tb_rx_demux.sv
// ---------------------------------------------------------------------------
// tb_rx_demux
//
// Directed bench for rx_demux (SWITCH_COUNT=2, CNT_W=4). Each step drives
// one cycle of inputs, waits for the rising edge, then samples 1 time unit
// later and compares against hand-derived expectations. Counter expectations
// follow the RX_DEMUX_STATS_EN build option.
// ---------------------------------------------------------------------------
module tb_rx_demux;

  localparam logic [63:0] VALL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] VPART = 64'h0000_0000_0000_FFFF;
  localparam logic [1:0]  M_IDLE = 2'b00;
  localparam logic [1:0]  M_OS   = 2'b01;
  localparam logic [1:0]  M_DATA = 2'b10;

  logic         clk;
  logic         reset;
  logic         rx_block_valid;
  logic         rx_sync_header;
  logic [511:0] rx_data;
  logic [63:0]  rx_valid;
  logic [63:0]  rx_datak;
  logic [511:0] data_out;
  logic [63:0]  data_valid_out;
  logic [63:0]  data_datak_out;
  logic         data_out_en;
  logic [511:0] os_out;
  logic [63:0]  os_valid_out;
  logic [63:0]  os_datak_out;
  logic         os_out_en;
  logic [1:0]   mode;
  logic         mode_change;
  logic [3:0]   os_blk_cnt;
  logic [3:0]   data_blk_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference counters: accepted blocks per type since last reset, saturating at 15.
  logic [3:0] m_os  = 4'd0;
  logic [3:0] m_dat = 4'd0;

  rx_demux #(.SWITCH_COUNT(2), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_block_valid (rx_block_valid),
    .rx_sync_header (rx_sync_header),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_datak       (rx_datak),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_datak_out (data_datak_out),
    .data_out_en    (data_out_en),
    .os_out         (os_out),
    .os_valid_out   (os_valid_out),
    .os_datak_out   (os_datak_out),
    .os_out_en      (os_out_en),
    .mode           (mode),
    .mode_change    (mode_change),
    .os_blk_cnt     (os_blk_cnt),
    .data_blk_cnt   (data_blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n) * 32'h0001_0101;
    return {16{w}};
  endfunction

  function automatic logic [63:0] kpat(input int n);
    logic [31:0] w;
    w = 32'h1234_5678 ^ (32'(n) * 32'h0F0F_0003);
    return {w, ~w};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic bv, input logic sh,
                      input logic [511:0] d, input logic [63:0] vm, input logic [63:0] km);
    reset          = rst;
    rx_block_valid = bv;
    rx_sync_header = sh;
    rx_data        = d;
    rx_valid       = vm;
    rx_datak       = km;
    @(posedge clk);
    if (rst) begin
      m_os  = 4'd0;
      m_dat = 4'd0;
    end else if (bv && (vm != 64'd0)) begin
      if (sh) begin
        if (m_os != 4'hF) m_os = m_os + 4'd1;
      end else begin
        if (m_dat != 4'hF) m_dat = m_dat + 4'd1;
      end
    end
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, pat(0), 64'd0, 64'd0);
  endtask

  task automatic expect_cnt(input string tag);
`ifdef RX_DEMUX_STATS_EN
    chk({tag, ".os_cnt"},   os_blk_cnt,   m_os);
    chk({tag, ".data_cnt"}, data_blk_cnt, m_dat);
`else
    chk({tag, ".os_cnt"},   os_blk_cnt,   4'd0);
    chk({tag, ".data_cnt"}, data_blk_cnt, 4'd0);
`endif
  endtask

  task automatic expect_mode(input string tag, input logic [1:0] m, input logic mc);
    chk({tag, ".mode"}, mode, m);
    chk({tag, ".mode_change"}, mode_change, mc);
  endtask

  task automatic expect_os(input string tag, input logic [511:0] d, input logic [63:0] vm,
                           input logic [63:0] km, input logic [511:0] data_hold);
    chk({tag, ".os_en"},      os_out_en,      1'b1);
    chk({tag, ".os_out"},     os_out,         d);
    chk({tag, ".os_valid"},   os_valid_out,   vm);
    chk({tag, ".os_datak"},   os_datak_out,   km);
    chk({tag, ".data_en"},    data_out_en,    1'b0);
    chk({tag, ".data_valid"}, data_valid_out, 64'd0);
    chk({tag, ".data_hold"},  data_out,       data_hold);
    expect_cnt(tag);
  endtask

  task automatic expect_data(input string tag, input logic [511:0] d, input logic [63:0] vm,
                             input logic [63:0] km, input logic [511:0] os_hold);
    chk({tag, ".data_en"},    data_out_en,    1'b1);
    chk({tag, ".data_out"},   data_out,       d);
    chk({tag, ".data_valid"}, data_valid_out, vm);
    chk({tag, ".data_datak"}, data_datak_out, km);
    chk({tag, ".os_en"},      os_out_en,      1'b0);
    chk({tag, ".os_valid"},   os_valid_out,   64'd0);
    chk({tag, ".os_hold"},    os_out,         os_hold);
    expect_cnt(tag);
  endtask

  task automatic expect_none(input string tag, input logic [511:0] os_hold,
                             input logic [511:0] data_hold);
    chk({tag, ".os_en"},      os_out_en,      1'b0);
    chk({tag, ".os_valid"},   os_valid_out,   64'd0);
    chk({tag, ".os_hold"},    os_out,         os_hold);
    chk({tag, ".data_en"},    data_out_en,    1'b0);
    chk({tag, ".data_valid"}, data_valid_out, 64'd0);
    chk({tag, ".data_hold"},  data_out,       data_hold);
    expect_cnt(tag);
  endtask

  task automatic expect_zero(input string tag);
    expect_none(tag, 512'd0, 512'd0);
    chk({tag, ".os_datak"},   os_datak_out,   64'd0);
    chk({tag, ".data_datak"}, data_datak_out, 64'd0);
    chk({tag, ".os_cnt0"},    os_blk_cnt,     4'd0);
    chk({tag, ".data_cnt0"},  data_blk_cnt,   4'd0);
    expect_mode(tag, M_IDLE, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rx_block_valid = 1'b0; rx_sync_header = 1'b0;
    rx_data = 512'd0; rx_valid = 64'd0; rx_datak = 64'd0;

    // Reset with a block presented: block discarded, everything zero.
    step(1'b1, 1'b1, 1'b1, pat(99), VALL, kpat(99));
    expect_zero("rst0");

    // Three back-to-back OS blocks from IDLE: switch to OS on the second.
    step(1'b0, 1'b1, 1'b1, pat(1), VALL, kpat(1));
    expect_os("os1", pat(1), VALL, kpat(1), 512'd0);
    expect_mode("os1", M_IDLE, 1'b0);
    step(1'b0, 1'b1, 1'b1, pat(2), VALL, kpat(2));
    expect_os("os2", pat(2), VALL, kpat(2), 512'd0);
    expect_mode("os2", M_OS, 1'b1);
    step(1'b0, 1'b1, 1'b1, pat(3), VALL, kpat(3));
    expect_os("os3", pat(3), VALL, kpat(3), 512'd0);
    expect_mode("os3", M_OS, 1'b0);
    idle_step();
    expect_none("idle1", pat(3), 512'd0);
    expect_mode("idle1", M_OS, 1'b0);

    // In OS: DATA, OS, DATA, DATA -> run 1,0,1,2 -> DATA on the fourth.
    step(1'b0, 1'b1, 1'b0, pat(4), VPART, kpat(4));
    expect_data("d4", pat(4), VPART, kpat(4), pat(3));
    expect_mode("d4", M_OS, 1'b0);
    step(1'b0, 1'b1, 1'b1, pat(5), VALL, kpat(5));
    expect_os("o5", pat(5), VALL, kpat(5), pat(4));
    expect_mode("o5", M_OS, 1'b0);
    step(1'b0, 1'b1, 1'b0, pat(6), VALL, kpat(6));
    expect_data("d6", pat(6), VALL, kpat(6), pat(5));
    expect_mode("d6", M_OS, 1'b0);
    step(1'b0, 1'b1, 1'b0, pat(7), VALL, kpat(7));
    expect_data("d7", pat(7), VALL, kpat(7), pat(5));
    expect_mode("d7", M_DATA, 1'b1);

    // In DATA: OS, five idle cycles, OS -> idle does not clear the run.
    step(1'b0, 1'b1, 1'b1, pat(8), VALL, kpat(8));
    expect_os("o8", pat(8), VALL, kpat(8), pat(7));
    expect_mode("o8", M_DATA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle_step();
      expect_none("idle5", pat(8), pat(7));
      expect_mode("idle5", M_DATA, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, pat(9), VALL, kpat(9));
    expect_os("o9", pat(9), VALL, kpat(9), pat(7));
    expect_mode("o9", M_OS, 1'b1);

    // rx_valid=0 blocks are ignored: no output, no run change.
    step(1'b0, 1'b1, 1'b1, pat(50), 64'd0, kpat(50));
    expect_none("ign_os", pat(9), pat(7));
    expect_mode("ign_os", M_OS, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, pat(51), 64'd0, kpat(51));
      expect_none("ign_d", pat(9), pat(7));
      expect_mode("ign_d", M_OS, 1'b0);
    end
    // Only one real DATA block so far: still OS; the next one switches.
    step(1'b0, 1'b1, 1'b0, pat(10), VALL, kpat(10));
    expect_data("d10", pat(10), VALL, kpat(10), pat(9));
    expect_mode("d10", M_OS, 1'b0);
    step(1'b0, 1'b1, 1'b0, pat(11), VALL, kpat(11));
    expect_data("d11", pat(11), VALL, kpat(11), pat(9));
    expect_mode("d11", M_DATA, 1'b1);

    // Reset mid-run from IDLE: run abandoned, no pulse, outputs cleared.
    step(1'b1, 1'b0, 1'b0, pat(0), 64'd0, 64'd0);
    expect_zero("rst1");
    step(1'b0, 1'b1, 1'b1, pat(12), VALL, kpat(12));
    expect_os("o12", pat(12), VALL, kpat(12), 512'd0);
    expect_mode("o12", M_IDLE, 1'b0);
    step(1'b1, 1'b1, 1'b1, pat(13), VALL, kpat(13));
    expect_zero("rst2");
    // First block after reset processed normally, run restarts at 1.
    step(1'b0, 1'b1, 1'b1, pat(14), VALL, kpat(14));
    expect_os("o14", pat(14), VALL, kpat(14), 512'd0);
    expect_mode("o14", M_IDLE, 1'b0);
    // Different type in IDLE restarts the candidate run.
    step(1'b0, 1'b1, 1'b0, pat(15), VALL, kpat(15));
    expect_data("d15", pat(15), VALL, kpat(15), pat(14));
    expect_mode("d15", M_IDLE, 1'b0);
    step(1'b0, 1'b1, 1'b0, pat(16), VALL, kpat(16));
    expect_data("d16", pat(16), VALL, kpat(16), pat(14));
    expect_mode("d16", M_DATA, 1'b1);

    // Counter saturation: 17 data blocks after reset.
    step(1'b1, 1'b0, 1'b0, pat(0), 64'd0, 64'd0);
    expect_zero("rst3");
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b0, pat(20 + i), VALL, kpat(20 + i));
      expect_data("sat", pat(20 + i), VALL, kpat(20 + i), 512'd0);
    end
    expect_mode("sat_end", M_DATA, 1'b0);
`ifdef RX_DEMUX_STATS_EN
    chk("sat_end.data_cnt15", data_blk_cnt, 4'd15);
`else
    chk("sat_end.data_cnt0", data_blk_cnt, 4'd0);
`endif
    chk("sat_end.os_cnt0", os_blk_cnt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
